// File: rtl/pitch_sequencer_pkg.sv
// pitch_sequencer_pkg
//   Shared definitions for the pitch sequencer: phase encodings, pitch-mode
//   constants, the wind-up tick table, the reset speed code and the width of
//   the phase timer.
//   No ports (package).
package pitch_sequencer_pkg;

  typedef enum logic [2:0] {
    PH_IDLE     = 3'd0,
    PH_ARM      = 3'd1,
    PH_WINDUP   = 3'd2,
    PH_RELEASE  = 3'd3,
    PH_COOLDOWN = 3'd4
  } phase_e;

  localparam logic [1:0] MODE_FASTBALL  = 2'd1;
  localparam logic [1:0] MODE_SLIDER    = 2'd2;
  localparam logic [1:0] MODE_CHANGE_UP = 2'd3;

  localparam logic [3:0] RESET_SPEED = 4'd3;

  // Wide enough for 3 * TICKS_PER_SEC and COOL_BASE + 15 with sane parameters.
  localparam int TIMER_W = 8;

  // Wind-up length in ticks; the illegal mode 0 falls back to FASTBALL timing.
  function automatic logic [TIMER_W-1:0] windup_ticks(input logic [1:0] m);
    case (m)
      MODE_SLIDER:    windup_ticks = TIMER_W'(3);
      MODE_CHANGE_UP: windup_ticks = TIMER_W'(4);
      default:        windup_ticks = TIMER_W'(2);
    endcase
  endfunction

endpackage

// File: rtl/pitch_sequencer_phase_timer.sv
// phase_timer
//   Tick-gated down-counter shared by all timed phases.
//   Ports:
//     clk, rst_n   clock and asynchronous active-low reset
//     tick         count enable (one clk wide)
//     load         load load_val (wins over tick)
//     clear        force the count to zero (wins over load)
//     load_val     phase length in ticks
//     done         high on the tick that completes the loaded count
module phase_timer
  import pitch_sequencer_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tick,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (tick && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // The last tick of a phase is the one that sees a count of one.
  assign done = tick && (cnt_q == W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pitch_sequencer.sv
// pitch_sequencer
//   Sequences one pitch: IDLE -> ARM (countdown) -> WINDUP -> RELEASE
//   (one-cycle launch) -> COOLDOWN -> IDLE. Speed and mode are frozen at the
//   request so the LED/display logic sees stable values while busy.
//   Optional feature macro: PITCH_QUEUE_EN (one-deep request queue during
//   COOLDOWN). Default build has no queue.
//   Handshake: pitchReq is a level; a request is its rising edge, taken only
//   in IDLE (or queued from COOLDOWN). abortReq is a level that overrides
//   everything on the next edge.
//   Ports:
//     clk, rstN       clock, asynchronous active-low reset
//     tick            timebase enable; phase lengths count ticks
//     pitchReq        debounced pitch button
//     abortReq        forces IDLE
//     speedCode/mode  live speed (0..8) and mode (1..3)
//     busy            high outside IDLE
//     phase           current state encoding (also the FSM debug view)
//     launch          high only in RELEASE
//     countdown       seconds left in ARM, else 0
//     latchedSpeed/latchedMode  values frozen at request time
//     pitchCount      completed launches, wrapping
module pitch_sequencer
  import pitch_sequencer_pkg::*;
#(
  parameter int TICKS_PER_SEC = 4,
  parameter int COOL_BASE     = 4
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic       tick,
  input  logic       pitchReq,
  input  logic       abortReq,
  input  logic [3:0] speedCode,
  input  logic [1:0] mode,
  output logic       busy,
  output logic [2:0] phase,
  output logic       launch,
  output logic [1:0] countdown,
  output logic [3:0] latchedSpeed,
  output logic [1:0] latchedMode,
  output logic [7:0] pitchCount
);

  phase_e               state_q, state_d;
  logic                 req_q, req_d;
  logic                 busy_q, busy_d;
  logic                 launch_q, launch_d;
  logic [1:0]           countdown_q, countdown_d;
  logic [3:0]           lspeed_q, lspeed_d;
  logic [1:0]           lmode_q, lmode_d;
  logic [7:0]           count_q, count_d;
  logic [TIMER_W-1:0]   sec_q, sec_d;      // ticks elapsed in the current ARM second
`ifdef PITCH_QUEUE_EN
  logic                 pending_q, pending_d;
`endif

  logic                 req_edge;
  logic                 start;
  logic                 tmr_load;
  logic                 tmr_clear;
  logic [TIMER_W-1:0]   tmr_val;
  logic                 tmr_done;

  phase_timer #(.W(TIMER_W)) u_timer (
    .clk      (clk),
    .rst_n    (rstN),
    .tick     (tick),
    .load     (tmr_load),
    .clear    (tmr_clear),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  assign req_edge = pitchReq && !req_q;

  always_comb begin
    state_d     = state_q;
    req_d       = pitchReq;
    countdown_d = countdown_q;
    lspeed_d    = lspeed_q;
    lmode_d     = lmode_q;
    count_d     = count_q;
    sec_d       = sec_q;
`ifdef PITCH_QUEUE_EN
    pending_d   = pending_q;
`endif
    start       = 1'b0;
    tmr_load    = 1'b0;
    tmr_clear   = 1'b0;
    tmr_val     = '0;

    case (state_q)
      PH_IDLE: begin
        if (req_edge) start = 1'b1;
      end
      PH_ARM: begin
        if (tmr_done) begin
          state_d     = PH_WINDUP;
          tmr_load    = 1'b1;
          tmr_val     = windup_ticks(lmode_q);
          countdown_d = 2'd0;
          sec_d       = '0;
        end else if (tick) begin
          if (sec_q == TIMER_W'(TICKS_PER_SEC - 1)) begin
            sec_d       = '0;
            countdown_d = countdown_q - 2'd1;
          end else begin
            sec_d = sec_q + TIMER_W'(1);
          end
        end
      end
      PH_WINDUP: begin
        if (tmr_done) begin
          state_d   = PH_RELEASE;
          tmr_clear = 1'b1;
        end
      end
      PH_RELEASE: begin
        // Single clk cycle regardless of tick; the launch is counted here.
        state_d  = PH_COOLDOWN;
        tmr_load = 1'b1;
        tmr_val  = TIMER_W'(COOL_BASE) + TIMER_W'(lspeed_q);
        count_d  = count_q + 8'd1;
      end
      PH_COOLDOWN: begin
`ifdef PITCH_QUEUE_EN
        if (req_edge) pending_d = 1'b1;
        if (tmr_done) begin
          if (pending_q || req_edge) begin
            start     = 1'b1;
            pending_d = 1'b0;
          end else begin
            state_d   = PH_IDLE;
            tmr_clear = 1'b1;
          end
        end
`else
        if (tmr_done) begin
          state_d   = PH_IDLE;
          tmr_clear = 1'b1;
        end
`endif
      end
      default: begin
        state_d   = PH_IDLE;
        tmr_clear = 1'b1;
      end
    endcase

    if (start) begin
      state_d     = PH_ARM;
      lspeed_d    = speedCode;
      lmode_d     = mode;
      tmr_load    = 1'b1;
      tmr_val     = TIMER_W'(3 * TICKS_PER_SEC);
      countdown_d = 2'd3;
      sec_d       = '0;
    end

    // Abort overrides any transition but leaves a RELEASE-cycle count intact.
    if (abortReq) begin
      state_d     = PH_IDLE;
      tmr_load    = 1'b0;
      tmr_clear   = 1'b1;
      countdown_d = 2'd0;
      sec_d       = '0;
      lspeed_d    = lspeed_q;
      lmode_d     = lmode_q;
`ifdef PITCH_QUEUE_EN
      pending_d   = 1'b0;
`endif
    end

    busy_d   = (state_d != PH_IDLE);
    launch_d = (state_d == PH_RELEASE);
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q     <= PH_IDLE;
      req_q       <= 1'b0;
      busy_q      <= 1'b0;
      launch_q    <= 1'b0;
      countdown_q <= 2'd0;
      lspeed_q    <= RESET_SPEED;
      lmode_q     <= MODE_FASTBALL;
      count_q     <= 8'd0;
      sec_q       <= '0;
`ifdef PITCH_QUEUE_EN
      pending_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      busy_q      <= busy_d;
      launch_q    <= launch_d;
      countdown_q <= countdown_d;
      lspeed_q    <= lspeed_d;
      lmode_q     <= lmode_d;
      count_q     <= count_d;
      sec_q       <= sec_d;
`ifdef PITCH_QUEUE_EN
      pending_q   <= pending_d;
`endif
    end
  end

  assign phase        = state_q;
  assign busy         = busy_q;
  assign launch       = launch_q;
  assign countdown    = countdown_q;
  assign latchedSpeed = lspeed_q;
  assign latchedMode  = lmode_q;
  assign pitchCount   = count_q;

endmodule

// File: tb/tb_pitch_sequencer.sv
// tb_pitch_sequencer
//   Bench for pitch_sequencer. The expected phase timeline of a pitch is
//   derived from phase lengths in ticks and the tick pattern, then compared
//   cycle by cycle. Honors PITCH_QUEUE_EN for the queued-request scenario.
module tb_pitch_sequencer;

  localparam int TPS = 4;
  localparam int CB  = 4;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       tick = 1'b0;
  logic       pitchReq = 1'b0;
  logic       abortReq = 1'b0;
  logic [3:0] speedCode = 4'd3;
  logic [1:0] mode = 2'd1;
  logic       busy;
  logic [2:0] phase;
  logic       launch;
  logic [1:0] countdown;
  logic [3:0] latchedSpeed;
  logic [1:0] latchedMode;
  logic [7:0] pitchCount;

  pitch_sequencer #(.TICKS_PER_SEC(TPS), .COOL_BASE(CB)) dut (
    .clk          (clk),
    .rstN         (rstN),
    .tick         (tick),
    .pitchReq     (pitchReq),
    .abortReq     (abortReq),
    .speedCode    (speedCode),
    .mode         (mode),
    .busy         (busy),
    .phase        (phase),
    .launch       (launch),
    .countdown    (countdown),
    .latchedSpeed (latchedSpeed),
    .latchedMode  (latchedMode),
    .pitchCount   (pitchCount)
  );

  // clock / reset
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int exp_count = 0;
  int exp_ls = 3;
  int exp_lm = 1;
  int tick_per = 1;
  int tick_off = 0;
  logic [2:0] exp_q[$];

`ifdef PITCH_QUEUE_EN
  localparam bit QUEUE_EN = 1'b1;
`else
  localparam bit QUEUE_EN = 1'b0;
`endif

  // reference model helpers
  function automatic bit tick_of(input int r);
    return ((r + tick_off) % tick_per) == 0;
  endfunction

  function automatic int nth_tick(input int from, input int n);
    int seen = 0;
    for (int r = from; r < from + 100000; r++) begin
      if (tick_of(r)) seen++;
      if (seen == n) return r;
    end
    return from + 100000;
  endfunction

  function automatic int ticks_in(input int a, input int b);
    int n = 0;
    for (int r = a; r <= b; r++) if (tick_of(r)) n++;
    return n;
  endfunction

  function automatic int windup_of(input int m);
    if (m == 2) return 3;
    if (m == 3) return 4;
    return 2;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full pitch from an IDLE cycle r=0, checked every cycle up to the first
  // cycle after COOLDOWN. Returns without driving that last cycle.
  task automatic run_pitch(input int spd, input int md, input bit extra_arm, input bit cool_press);
    int arm_end, wind_end, rel, cool_end, last, cnt0, nspd, nmd;
    int ep, ecd, els, elm, ecnt;
    bit queued;
    arm_end  = nth_tick(1, 3 * TPS);
    wind_end = nth_tick(arm_end + 1, windup_of(md));
    rel      = wind_end + 1;
    cool_end = nth_tick(rel + 1, CB + spd);
    last     = cool_end + 1;
    queued   = cool_press && QUEUE_EN;
    cnt0     = exp_count;
    nspd     = $urandom_range(0, 8);
    nmd      = $urandom_range(0, 3);
    exp_q.delete();
    for (int r = 0; r <= last; r++) begin
      if (r == 0)             exp_q.push_back(3'd0);
      else if (r <= arm_end)  exp_q.push_back(3'd1);
      else if (r <= wind_end) exp_q.push_back(3'd2);
      else if (r == rel)      exp_q.push_back(3'd3);
      else if (r <= cool_end) exp_q.push_back(3'd4);
      else                    exp_q.push_back(queued ? 3'd1 : 3'd0);
    end
    for (int r = 0; r <= last; r++) begin
      ep   = int'(exp_q.pop_front());
      ecd  = (ep == 1) ? ((queued && r == last) ? 3 : 3 - ticks_in(1, r - 1) / TPS) : 0;
      els  = (r == 0) ? exp_ls : ((queued && r == last) ? nspd : spd);
      elm  = (r == 0) ? exp_lm : ((queued && r == last) ? nmd : md);
      ecnt = (r > rel) ? (cnt0 + 1) % 256 : cnt0;
      vectors++;
      if (phase !== 3'(ep)) begin
        miscompares++;
        $display("FAIL phase r=%0d got %0d exp %0d", r, phase, ep);
      end
      vectors++;
      if (busy !== (ep != 0)) begin
        miscompares++;
        $display("FAIL busy r=%0d got %0b exp %0b", r, busy, (ep != 0));
      end
      vectors++;
      if (launch !== (r == rel)) begin
        miscompares++;
        $display("FAIL launch r=%0d got %0b exp %0b", r, launch, (r == rel));
      end
      vectors++;
      if (countdown !== 2'(ecd)) begin
        miscompares++;
        $display("FAIL countdown r=%0d got %0d exp %0d", r, countdown, ecd);
      end
      vectors++;
      if (latchedSpeed !== 4'(els) || latchedMode !== 2'(elm)) begin
        miscompares++;
        $display("FAIL latched r=%0d got %0d/%0d exp %0d/%0d", r, latchedSpeed, latchedMode, els, elm);
      end
      vectors++;
      if (pitchCount !== 8'(ecnt)) begin
        miscompares++;
        $display("FAIL pitchCount r=%0d got %0d exp %0d", r, pitchCount, ecnt);
      end
      if (r < last) begin
        tick = tick_of(r);
        if (r == 0) begin
          pitchReq  = 1'b1;
          speedCode = 4'(spd);
          mode      = 2'(md);
        end
        if (r == 1) pitchReq = 1'b0;
        if (r == 2) begin
          speedCode = 4'($urandom_range(0, 8));
          mode      = 2'($urandom_range(0, 3));
        end
        if (extra_arm && r == 3) pitchReq = 1'b1;
        if (extra_arm && r == 5) pitchReq = 1'b0;
        if (cool_press && r == rel + 1) begin
          pitchReq  = 1'b1;
          speedCode = 4'(nspd);
          mode      = 2'(nmd);
        end
        if (cool_press && r == rel + 2) pitchReq = 1'b0;
        step();
      end
    end
    exp_count = (cnt0 + 1) % 256;
    exp_ls    = queued ? nspd : spd;
    exp_lm    = queued ? nmd : md;
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    #23;
    vectors++;
    if (phase !== 3'd0 || busy !== 1'b0 || launch !== 1'b0 || countdown !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_ctrl got ph=%0d busy=%0b launch=%0b cd=%0d exp 0/0/0/0", phase, busy, launch, countdown);
    end
    vectors++;
    if (latchedSpeed !== 4'd3 || latchedMode !== 2'd1 || pitchCount !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_data got %0d/%0d/%0d exp 3/1/0", latchedSpeed, latchedMode, pitchCount);
    end
    @(negedge clk);
    rstN = 1'b1;
    step();
  endtask

  task automatic test_basic();
    tick_per = 1;
    tick_off = 0;
    run_pitch(3, 1, 1'b0, 1'b0);
  endtask

  task automatic test_changeup();
    tick_per = 1;
    run_pitch(8, 3, 1'b1, 1'b0);
  endtask

  task automatic test_abort();
    int spd, md;
    tick_per = 1;
    spd = $urandom_range(0, 8);
    md  = 1;
    for (int r = 0; r < 13; r++) begin
      tick = 1'b1;
      if (r == 0) begin
        pitchReq  = 1'b1;
        speedCode = 4'(spd);
        mode      = 2'(md);
      end
      if (r == 1) pitchReq = 1'b0;
      step();
    end
    vectors++;
    if (phase !== 3'd2) begin
      miscompares++;
      $display("FAIL abort_pre got %0d exp 2", phase);
    end
    abortReq = 1'b1;
    step();
    abortReq = 1'b0;
    vectors++;
    if (phase !== 3'd0 || busy !== 1'b0 || countdown !== 2'd0) begin
      miscompares++;
      $display("FAIL abort_idle got ph=%0d busy=%0b cd=%0d exp 0/0/0", phase, busy, countdown);
    end
    vectors++;
    if (latchedSpeed !== 4'(spd) || latchedMode !== 2'(md) || pitchCount !== 8'(exp_count)) begin
      miscompares++;
      $display("FAIL abort_hold got %0d/%0d/%0d exp %0d/%0d/%0d", latchedSpeed, latchedMode, pitchCount, spd, md, exp_count);
    end
    for (int r = 0; r < 20; r++) begin
      vectors++;
      if (launch !== 1'b0 || phase !== 3'd0) begin
        miscompares++;
        $display("FAIL abort_quiet r=%0d got launch=%0b ph=%0d exp 0/0", r, launch, phase);
      end
      step();
    end
    // press and abort together, then keep the button held
    pitchReq = 1'b1;
    abortReq = 1'b1;
    step();
    abortReq = 1'b0;
    for (int r = 0; r < 4; r++) begin
      vectors++;
      if (phase !== 3'd0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL abort_press r=%0d got ph=%0d busy=%0b exp 0/0", r, phase, busy);
      end
      step();
    end
    pitchReq = 1'b0;
    step();
    exp_ls = spd;
    exp_lm = md;
  endtask

  task automatic test_slow_tick();
    tick_per = 10;
    tick_off = 0;
    run_pitch(3, 1, 1'b1, 1'b0);
    tick_per = 10;
    tick_off = $urandom_range(0, 9);
    run_pitch($urandom_range(0, 8), $urandom_range(0, 3), 1'b0, 1'b0);
    tick_off = 0;
  endtask

  task automatic test_queue();
    tick_per = 1;
    run_pitch($urandom_range(0, 8), $urandom_range(1, 3), 1'b0, 1'b1);
    abortReq = 1'b1;
    step();
    abortReq = 1'b0;
    for (int r = 0; r < 5; r++) begin
      vectors++;
      if (phase !== 3'd0) begin
        miscompares++;
        $display("FAIL queue_clear r=%0d got %0d exp 0", r, phase);
      end
      step();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++) begin
      tick_per = $urandom_range(1, 3);
      tick_off = $urandom_range(0, 2);
      run_pitch($urandom_range(0, 8), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0);
    end
    tick_off = 0;
  endtask

  task automatic test_back_to_back_wrap();
    int n;
    tick_per = 1;
    n = 256 - exp_count;
    for (int i = 0; i < n; i++) begin
      run_pitch($urandom_range(0, 8), $urandom_range(0, 3), 1'b0, 1'b0);
    end
    vectors++;
    if (pitchCount !== 8'd0) begin
      miscompares++;
      $display("FAIL wrap got %0d exp 0", pitchCount);
    end
  endtask

  task automatic test_reset_mid();
    tick_per = 1;
    for (int r = 0; r < 18; r++) begin
      tick = 1'b1;
      if (r == 0) begin
        pitchReq  = 1'b1;
        speedCode = 4'd3;
        mode      = 2'd1;
      end
      if (r == 1) pitchReq = 1'b0;
      step();
    end
    vectors++;
    if (phase !== 3'd4) begin
      miscompares++;
      $display("FAIL reset_mid_pre got %0d exp 4", phase);
    end
    #2;
    rstN = 1'b0;
    #1;
    vectors++;
    if (phase !== 3'd0 || busy !== 1'b0 || launch !== 1'b0 || countdown !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_mid_ctrl got ph=%0d busy=%0b launch=%0b cd=%0d exp 0/0/0/0", phase, busy, launch, countdown);
    end
    vectors++;
    if (latchedSpeed !== 4'd3 || latchedMode !== 2'd1 || pitchCount !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_mid_data got %0d/%0d/%0d exp 3/1/0", latchedSpeed, latchedMode, pitchCount);
    end
    @(negedge clk);
    rstN = 1'b1;
    step();
    exp_count = 0;
    exp_ls = 3;
    exp_lm = 1;
    run_pitch(2, 2, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_changeup();
    test_abort();
    test_slow_tick();
    test_queue();
    test_random();
    test_back_to_back_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    miscompares++;
    $display("FAIL timeout got running exp finished");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
